// File: rtl/riscv_defs.sv
// Shared RV32I control definitions: opcodes, ALUOp codes, datapath select codes.
// Latency: n/a (constants, types and one combinational helper).
// Backpressure: n/a.
package riscv_defs;

  // Opcode field IR[6:0]
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp into the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Moore part of the control word; everything here is a pure decode of state.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       pc_update;  // unconditional PC load outside FETCH (JAL)
    logic       branch;     // PC load qualified by the ALU zero flag
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bundle between the main FSM and the datapath/memory side.
// Latency: n/a (wires only).
// Backpressure: mem_req is held until mem_ready; the FSM stalls meanwhile.
// master: FSM side (drives strobes/selects, sees op/zero/mem_ready).
// slave:  datapath side (drives op/zero/mem_ready, sees strobes/selects).
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic       illegal_instr;
  logic       halted;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal_instr, halted
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal_instr, halted
  );
endinterface

// File: rtl/instret_counter.sv
// Retired-instruction counter: CNT_W-bit enable counter, wraps modulo 2^CNT_W.
// Latency: count visible the cycle after en_i.
// Backpressure: none; en_i is sampled every cycle.
// Ports: clk, rst (async active-high), en_i (increment), cnt_o (count).
module instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = en_i ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core (fetch/decode/execute/mem/writeback).
// Latency: 3 (beq) to 5 (lw) cycles per instruction plus memory wait cycles.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold mem_req and address selects until mem_ready.
// Ports: clk, rst (async active-high); ctl_if (master modport: op/zero/mem_ready in,
//        strobes and mux selects out); instret_o (retired instruction count).
module multicycle_control_fsm
  import riscv_defs::*;
#(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master ctl_if,
  output logic [CNT_W-1:0]         instret_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       retire;
  logic       fetch_go;
  logic       illegal;
  ctrl_t      c;

  // Next state and retire strobe
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (ctl_if.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctl_if.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctl_if.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ctl_if.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (ctl_if.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Moore control word
  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        // Computes the branch target early (OldPC + imm) into ALUOut.
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        // ALUResult = OldPC + 4 is the link value; ALUOut holds the target from DECODE.
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign fetch_go = (state_q == S_FETCH) && ctl_if.mem_ready;
  assign illegal  = (state_q == S_DECODE) && !is_supported(ctl_if.op);

  // Strobes are forced low while rst is asserted: the async reset moves the
  // state to FETCH at once, whose decode would otherwise raise mem_req.
  assign ctl_if.mem_req       = c.mem_req & ~rst;
  assign ctl_if.PCWrite       = (fetch_go | c.pc_update | (c.branch & ctl_if.zero)) & ~rst;
  assign ctl_if.IRWrite       = fetch_go & ~rst;
  assign ctl_if.MemWrite      = c.mem_write & ~rst;
  assign ctl_if.RegWrite      = c.reg_write & ~rst;
  assign ctl_if.illegal_instr = illegal & ~rst;
  assign ctl_if.AdrSrc        = c.adr_src;
  assign ctl_if.ResultSrc     = c.result_src;
  assign ctl_if.ALUSrcA       = c.alu_src_a;
  assign ctl_if.ALUSrcB       = c.alu_src_b;
  assign ctl_if.ALUOp         = c.alu_op;
  assign ctl_if.halted        = (state_q == S_HALT);

  instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en_i  (retire),
    .cnt_o (instret_o)
  );

endmodule
